// File: rtl/sensor_filter_bank_if.sv
// rtl/sensor_filter_bank_if.sv - control, sensor and actuator bundle for sensor_filter_bank
interface sensor_filter_bank_if #(
    parameter int CHANNELS = 4
);
    logic                Start;
    logic                Latch;
    logic                Clear;
    logic [CHANNELS-1:0] Sensor;
    logic [CHANNELS-1:0] Actuator;
    logic [CHANNELS-1:0] Busy;

    modport master (
        output Start,
        output Latch,
        output Clear,
        output Sensor,
        input  Actuator,
        input  Busy
    );

    modport slave (
        input  Start,
        input  Latch,
        input  Clear,
        input  Sensor,
        output Actuator,
        output Busy
    );
endinterface

// File: rtl/sensor_filter_bank.sv
// rtl/sensor_filter_bank.sv - per-channel on/off debounce filter with optional latch mode
module sensor_filter_bank #(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int ON_DELAY  = 5,
    parameter int OFF_DELAY = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sensor_filter_bank_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ON     = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ON_D  = CNT_W'(ON_DELAY);
    localparam logic [CNT_W-1:0] OFF_D = CNT_W'(OFF_DELAY);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state_q [CHANNELS];
    state_t           state_d [CHANNELS];
    logic [CNT_W-1:0] cnt_q   [CHANNELS];
    logic [CNT_W-1:0] cnt_d   [CHANNELS];

    logic [CHANNELS-1:0] act_vec;
    logic [CHANNELS-1:0] busy_vec;

    // State and counter registers for every channel; reset drops all channels to IDLE at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state and counter update; Clear overrides every transition, and the
    // counter always returns to zero when a channel settles in IDLE or ON
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (bus.Clear) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (bus.Start && bus.Sensor[i]) begin
                            if (ON_DELAY == 1) begin
                                state_d[i] = ON;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = ARM;
                                cnt_d[i]   = ONE;
                            end
                        end
                    end
                    ARM: begin
                        // Any break in qualification discards the partial count
                        if (bus.Start && bus.Sensor[i]) begin
                            if (cnt_q[i] + ONE == ON_D) begin
                                state_d[i] = ON;
                                cnt_d[i]   = '0;
                            end else begin
                                cnt_d[i]   = cnt_q[i] + ONE;
                            end
                        end else begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end
                    end
                    ON: begin
                        // Start has no say once on; only a low Sensor outside latch mode starts the fall
                        if (!bus.Latch && !bus.Sensor[i]) begin
                            if (OFF_DELAY == 1) begin
                                state_d[i] = IDLE;
                                cnt_d[i]   = '0;
                            end else begin
                                state_d[i] = DISARM;
                                cnt_d[i]   = ONE;
                            end
                        end
                    end
                    DISARM: begin
                        if (bus.Latch || bus.Sensor[i]) begin
                            state_d[i] = ON;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] + ONE == OFF_D) begin
                            state_d[i] = IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i]   = cnt_q[i] + ONE;
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
        end
    end

    // Outputs are pure decodes of the state register, so they carry no input path
    always_comb begin
        act_vec  = '0;
        busy_vec = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            act_vec[i]  = (state_q[i] == ON)  || (state_q[i] == DISARM);
            busy_vec[i] = (state_q[i] == ARM) || (state_q[i] == DISARM);
        end
    end

    assign bus.Actuator = act_vec;
    assign bus.Busy     = busy_vec;

endmodule

// File: tb/tb_sensor_filter_bank.sv
// tb/tb_sensor_filter_bank.sv - directed self-checking bench for sensor_filter_bank
module tb_sensor_filter_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       start_r  = 1'b0;
    logic       latch_r  = 1'b0;
    logic       clear_r  = 1'b0;
    logic [3:0] sensor_r = 4'h0;

    int checks = 0;
    int errors = 0;

    // Reference model state: index 0 = 5/5 delays, index 1 = 1/1 delays
    int m_q   [2][4];
    int m_l   [2][4];
    bit m_act [2][4];
    int on_d  [2] = '{5, 1};
    int off_d [2] = '{5, 1};

    sensor_filter_bank_if #(.CHANNELS(4)) bus_a ();
    sensor_filter_bank_if #(.CHANNELS(4)) bus_b ();

    assign bus_a.Start  = start_r;
    assign bus_a.Latch  = latch_r;
    assign bus_a.Clear  = clear_r;
    assign bus_a.Sensor = sensor_r;
    assign bus_b.Start  = start_r;
    assign bus_b.Latch  = latch_r;
    assign bus_b.Clear  = clear_r;
    assign bus_b.Sensor = sensor_r;

    sensor_filter_bank #(
        .CHANNELS (4),
        .CNT_W    (8),
        .ON_DELAY (5),
        .OFF_DELAY(5)
    ) dut_a (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_a)
    );

    sensor_filter_bank #(
        .CHANNELS (4),
        .CNT_W    (8),
        .ON_DELAY (1),
        .OFF_DELAY(1)
    ) dut_b (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                m_q[d][i]   = 0;
                m_l[d][i]   = 0;
                m_act[d][i] = 1'b0;
            end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) begin
                if (clear_r) begin
                    m_act[d][i] = 1'b0;
                    m_q[d][i]   = 0;
                    m_l[d][i]   = 0;
                end else if (!m_act[d][i]) begin
                    if (start_r && sensor_r[i]) begin
                        m_q[d][i]++;
                        if (m_q[d][i] >= on_d[d]) begin
                            m_act[d][i] = 1'b1;
                            m_q[d][i]   = 0;
                        end
                    end else begin
                        m_q[d][i] = 0;
                    end
                end else begin
                    if (latch_r || sensor_r[i]) begin
                        m_l[d][i] = 0;
                    end else begin
                        m_l[d][i]++;
                        if (m_l[d][i] >= off_d[d]) begin
                            m_act[d][i] = 1'b0;
                            m_l[d][i]   = 0;
                        end
                    end
                end
            end
    endtask

    function automatic logic [3:0] exp_act(input int d);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_act[d][i];
        return v;
    endfunction

    function automatic logic [3:0] exp_busy(input int d);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_act[d][i] ? (m_l[d][i] > 0) : (m_q[d][i] > 0);
        return v;
    endfunction

    // One clock edge: advance the model, then compare both DUTs after the edge settles
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_act_a",  {28'h0, bus_a.Actuator}, {28'h0, exp_act(0)});
        check("model_busy_a", {28'h0, bus_a.Busy},     {28'h0, exp_busy(0)});
        check("model_act_b",  {28'h0, bus_b.Actuator}, {28'h0, exp_act(1)});
        check("model_busy_b", {28'h0, bus_b.Busy},     {28'h0, exp_busy(1)});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_act",  {28'h0, bus_a.Actuator}, 32'h0);
        check("reset_busy", {28'h0, bus_a.Busy},     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Rise filter on channel 0
        start_r  = 1'b1;
        sensor_r = 4'b0001;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rise_busy_e%0d", k), {31'h0, bus_a.Busy[0]},     32'h1);
            check($sformatf("rise_act_e%0d", k),  {31'h0, bus_a.Actuator[0]}, 32'h0);
        end
        tick();
        check("rise_act_e5",  {31'h0, bus_a.Actuator[0]}, 32'h1);
        check("rise_busy_e5", {31'h0, bus_a.Busy[0]},     32'h0);

        // Fall filter: 3-cycle dropout, one high, then 5 lows
        sensor_r = 4'b0000;
        ticks(3);
        check("dropout_act",  {31'h0, bus_a.Actuator[0]}, 32'h1);
        check("dropout_busy", {31'h0, bus_a.Busy[0]},     32'h1);
        sensor_r = 4'b0001;
        tick();
        check("dropout_back_on", {31'h0, bus_a.Busy[0]}, 32'h0);
        sensor_r = 4'b0000;
        ticks(4);
        check("fall_act_e4", {31'h0, bus_a.Actuator[0]}, 32'h1);
        tick();
        check("fall_act_e5",  {31'h0, bus_a.Actuator[0]}, 32'h0);
        check("fall_busy_e5", {31'h0, bus_a.Busy[0]},     32'h0);

        // Four-cycle glitch never turns the actuator on
        sensor_r = 4'b0001;
        ticks(4);
        check("glitch4_act", {31'h0, bus_a.Actuator[0]}, 32'h0);
        sensor_r = 4'b0000;
        tick();
        check("glitch4_idle_busy", {31'h0, bus_a.Busy[0]}, 32'h0);

        // Start gating on channel 1
        start_r  = 1'b0;
        sensor_r = 4'b0010;
        ticks(20);
        check("nostart_act",  {31'h0, bus_a.Actuator[1]}, 32'h0);
        check("nostart_busy", {31'h0, bus_a.Busy[1]},     32'h0);
        start_r = 1'b1;
        ticks(2);
        check("arm_busy", {31'h0, bus_a.Busy[1]}, 32'h1);
        start_r = 1'b0;
        tick();
        check("start_drop_idle", {31'h0, bus_a.Busy[1]}, 32'h0);
        start_r = 1'b1;
        ticks(4);
        check("requal_e4_act", {31'h0, bus_a.Actuator[1]}, 32'h0);
        tick();
        check("requal_e5_act", {31'h0, bus_a.Actuator[1]}, 32'h1);
        sensor_r = 4'b0000;
        ticks(5);
        check("ch1_off", {31'h0, bus_a.Actuator[1]}, 32'h0);

        // Latch mode on channel 2
        latch_r  = 1'b1;
        sensor_r = 4'b0100;
        ticks(5);
        check("latch_on", {31'h0, bus_a.Actuator[2]}, 32'h1);
        sensor_r = 4'b0000;
        ticks(50);
        check("latch_hold_act",  {31'h0, bus_a.Actuator[2]}, 32'h1);
        check("latch_hold_busy", {31'h0, bus_a.Busy[2]},     32'h0);
        clear_r = 1'b1;
        tick();
        check("clear_act", {31'h0, bus_a.Actuator[2]}, 32'h0);
        clear_r  = 1'b0;
        sensor_r = 4'b0100;
        ticks(4);
        clear_r = 1'b1;
        tick();
        check("clear_wins_act",  {31'h0, bus_a.Actuator[2]}, 32'h0);
        check("clear_wins_busy", {31'h0, bus_a.Busy[2]},     32'h0);
        clear_r = 1'b0;
        tick();
        check("requal_after_clear", {31'h0, bus_a.Busy[2]}, 32'h1);
        sensor_r = 4'b0000;
        latch_r  = 1'b0;
        tick();

        // Staggered, overlapping stimuli on all channels of both builds
        for (int t = 0; t < 300; t++) begin
            for (int i = 0; i < 4; i++)
                sensor_r[i] = (((t + 7 * i) / (2 + 2 * i)) % 2) == 1;
            start_r = (t % 29) != 5;
            latch_r = (t >= 150) && (t < 200);
            clear_r = (t % 61) == 30;
            tick();
        end

        // Asynchronous reset mid-cycle with every channel on
        clear_r  = 1'b0;
        latch_r  = 1'b1;
        start_r  = 1'b1;
        sensor_r = 4'b1111;
        ticks(6);
        check("all_on_a", {28'h0, bus_a.Actuator}, 32'hF);
        check("all_on_b", {28'h0, bus_b.Actuator}, 32'hF);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_act_a",  {28'h0, bus_a.Actuator}, 32'h0);
        check("async_rst_busy_a", {28'h0, bus_a.Busy},     32'h0);
        check("async_rst_act_b",  {28'h0, bus_b.Actuator}, 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        latch_r  = 1'b0;
        sensor_r = 4'b0000;
        ticks(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
